// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper phase sequencer: state encoding,
// direction constants, the half-step coil table and the step-size helper.
package stepper_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Half-step coil patterns {ph3,ph2,ph1,ph0}; entry 0 is the LSB slice.
  // Odd entries energise two adjacent coils (full-step positions).
  localparam logic [7:0][3:0] PHASE_TABLE = {
    4'b1001, 4'b1000, 4'b1100, 4'b0100,
    4'b0110, 4'b0010, 4'b0011, 4'b0001
  };

  // Index distance of one commanded step. A full step from a single-coil
  // (even) position moves only one slot so it lands back on a two-coil pattern.
  function automatic logic [2:0] step_amount(input logic half, input logic idx_odd);
    return (!half && idx_odd) ? 3'd2 : 3'd1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter with a done flag; times the dwell after each step.
module step_timer #(
  parameter int W = 20
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clear,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Count down to zero and stop; clear wins over load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_done = (r_cnt == '0);

endmodule

// File: rtl/stepper_phase_seq.sv
// Step/direction to 4-wire stepper coil sequencer with dwell enforcement,
// signed position tracking and reduced-duty chopping while holding.
module stepper_phase_seq
  import stepper_pkg::*;
#(
  parameter int DWELL_CYC = 1048576,
  parameter int IDLE_CYC  = 8388608,
  parameter int HOLD_DUTY = 4,
  parameter int POS_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_step_req,
  input  logic             i_step_dir,
  input  logic             i_step_half,
  output logic             o_step_rdy,
  output logic [3:0]       o_phase,
  output logic [POS_W-1:0] o_pos,
  output logic             o_holding
);

  localparam int DWELL_W = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int IDLE_W  = (IDLE_CYC  > 1) ? $clog2(IDLE_CYC)  : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYC - 1);
  localparam logic [IDLE_W-1:0]  IDLE_MAX   = IDLE_W'(IDLE_CYC - 1);
  localparam logic [4:0]         DUTY5      = 5'(HOLD_DUTY);

  state_t             r_state;
  logic [2:0]         r_index;
  logic [POS_W-1:0]   r_pos;
  logic [IDLE_W-1:0]  r_idle_cnt;
  logic [3:0]         r_pwm;
  logic [3:0]         r_phase;

  state_t             w_state_next;
  logic [2:0]         w_index_next;
  logic [POS_W-1:0]   w_pos_next;
  logic [IDLE_W-1:0]  w_idle_next;
  logic [2:0]         w_step;
  logic               w_rdy;
  logic               w_accept;
  logic               w_dwell_load;
  logic               w_dwell_clear;
  logic               w_dwell_done;
  logic               w_chop_on;

  step_timer #(.W(DWELL_W)) u_dwell (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clear    (w_dwell_clear),
    .i_load     (w_dwell_load),
    .i_load_val (DWELL_LOAD),
    .o_done     (w_dwell_done)
  );

  // Next-state, index, position and idle-counter decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    w_state_next  = r_state;
    w_index_next  = r_index;
    w_pos_next    = r_pos;
    w_idle_next   = r_idle_cnt;
    w_dwell_load  = 1'b0;
    w_dwell_clear = 1'b0;
    w_rdy         = i_en && (r_state == IDLE || r_state == HOLD);
    w_accept      = w_rdy && i_step_req;
    w_step        = step_amount(i_step_half, r_index[0]);

    if (!i_en) begin
      // Disable aborts any dwell and restarts the idle timeout from scratch.
      w_state_next  = IDLE;
      w_idle_next   = '0;
      w_dwell_clear = 1'b1;
    end else if (w_accept) begin
      if (i_step_dir == DIR_FWD) begin
        w_index_next = r_index + w_step;
        w_pos_next   = r_pos + POS_W'(w_step);
      end else begin
        w_index_next = r_index - w_step;
        w_pos_next   = r_pos - POS_W'(w_step);
      end
      w_state_next = DWELL;
      w_dwell_load = 1'b1;
      w_idle_next  = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_idle_cnt == IDLE_MAX) w_state_next = HOLD;
          else                        w_idle_next  = r_idle_cnt + IDLE_W'(1);
        end
        DWELL: begin
          if (w_dwell_done) begin
            w_state_next = IDLE;
            w_idle_next  = '0;
          end
        end
        HOLD:    ;
        default: w_state_next = IDLE;
      endcase
    end

    // Chopping follows the state being entered, so leaving HOLD restores
    // full drive on the same edge that registers the new pattern.
    w_chop_on = (w_state_next != HOLD) || ({1'b0, r_pwm} < DUTY5);
  end

  // FSM, index, position, PWM phase and registered coil drive.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_index    <= 3'd1;
      r_pos      <= '0;
      r_idle_cnt <= '0;
      r_pwm      <= 4'd0;
      r_phase    <= 4'b0000;
    end else begin
      r_state    <= w_state_next;
      r_index    <= w_index_next;
      r_pos      <= w_pos_next;
      r_idle_cnt <= w_idle_next;
      r_pwm      <= r_pwm + 4'd1;
      r_phase    <= i_en ? (PHASE_TABLE[w_index_next] & {4{w_chop_on}}) : 4'b0000;
    end
  end

  assign o_step_rdy = w_rdy;
  assign o_phase    = r_phase;
  assign o_pos      = r_pos;
  assign o_holding  = (r_state == HOLD);

endmodule
